// File: rtl/fpga_robots_game_cell_access.sv
// Cell-level client of the video tile map port: read, write, test-and-set and bulk clear
// of the 120x96 play area, packing two 2-bit cells into bits [3:0] of each tile map byte.
module fpga_robots_game_cell_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [1:0]  cmd_val,
    output logic        rsp_valid,
    output logic [1:0]  rsp_val,
    output logic        rsp_err,
    output logic [12:0] tm_adr,
    input  logic [7:0]  tm_red,
    output logic [7:0]  tm_wrt,
    output logic        tm_wen
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADR, S_RD_DAT, S_WR, S_CLR, S_RESP
    } state_t;

    localparam logic [1:0]  OP_READ  = 2'd0;
    localparam logic [1:0]  OP_CLEAR = 2'd2;
    localparam logic [1:0]  OP_TAS   = 2'd3;
    localparam logic [6:0]  LAST_COL = 7'd119;
    localparam logic [12:0] LAST_ADR = 13'h17F7;

    function automatic logic [1:0] cell_of(input logic [7:0] b, input logic hi);
        return hi ? b[3:2] : b[1:0];
    endfunction

    function automatic logic [7:0] cell_merge(input logic [7:0] b, input logic hi,
                                              input logic [1:0] v);
        logic [7:0] r;
        r = b;
        if (hi) r[3:2] = v;
        else    r[1:0] = v;
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        hi_q, hi_d;
    logic [1:0]  val_q, val_d;
    logic [1:0]  old_q, old_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_val_q, rsp_val_d;
    logic        rsp_err_q, rsp_err_d;
    logic [12:0] tm_adr_q, tm_adr_d;
    logic [7:0]  tm_wrt_q, tm_wrt_d;
    logic        tm_wen_q, tm_wen_d;

    logic        out_of_range;
    logic [1:0]  old_cell;
    logic [6:0]  clr_col;
    logic [5:0]  clr_row;

    assign out_of_range = (cmd_x >= 7'd120) || (cmd_y >= 7'd96);
    assign old_cell     = cell_of(tm_red, hi_q);
    assign clr_col      = tm_adr_q[6:0];
    assign clr_row      = tm_adr_q[12:7];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hi_d        = hi_q;
        val_d       = val_q;
        old_d       = old_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_val_d   = rsp_val_q;
        rsp_err_d   = rsp_err_q;
        tm_adr_d    = tm_adr_q;
        tm_wrt_d    = tm_wrt_q;
        tm_wen_d    = 1'b0;

        if (cmd_ready_q && cmd_valid) begin
            // Acceptance is possible in IDLE and in the response cycle alike
            op_d        = cmd_op;
            hi_d        = cmd_y[0];
            val_d       = cmd_val;
            cmd_ready_d = 1'b0;
            if (cmd_op == OP_CLEAR) begin
                state_d  = S_CLR;
                tm_adr_d = '0;
                tm_wrt_d = '0;
                tm_wen_d = 1'b1;
            end else if (out_of_range) begin
                state_d = S_RESP;
            end else begin
                state_d  = S_RD_ADR;
                tm_adr_d = {cmd_y[6:1], cmd_x};
            end
        end else begin
            case (state_q)
                S_RESP: begin
                    if (cmd_ready_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // Rejected coordinates: answer one cycle after acceptance
                        rsp_valid_d = 1'b1;
                        rsp_val_d   = 2'd0;
                        rsp_err_d   = 1'b1;
                        cmd_ready_d = 1'b1;
                    end
                end
                S_RD_ADR: state_d = S_RD_DAT;
                S_RD_DAT: begin
                    old_d = old_cell;
                    if (op_q == OP_READ || (op_q == OP_TAS && old_cell != 2'd0)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_val_d   = old_cell;
                        rsp_err_d   = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        state_d  = S_WR;
                        tm_wen_d = 1'b1;
                        tm_wrt_d = cell_merge(tm_red, hi_q, val_q);
                    end
                end
                S_WR: begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_val_d   = old_q;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                end
                S_CLR: begin
                    if (tm_adr_q == LAST_ADR) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_val_d   = 2'd0;
                        rsp_err_d   = 1'b0;
                        cmd_ready_d = 1'b1;
                    end else begin
                        // Skip the status columns 120-127 by wrapping at 119
                        tm_wen_d = 1'b1;
                        if (clr_col == LAST_COL) tm_adr_d = {clr_row + 6'd1, 7'd0};
                        else                     tm_adr_d = {clr_row, clr_col + 7'd1};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            hi_q        <= 1'b0;
            val_q       <= '0;
            old_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_val_q   <= '0;
            rsp_err_q   <= 1'b0;
            tm_adr_q    <= '0;
            tm_wrt_q    <= '0;
            tm_wen_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            val_q       <= val_d;
            old_q       <= old_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_val_q   <= rsp_val_d;
            rsp_err_q   <= rsp_err_d;
            tm_adr_q    <= tm_adr_d;
            tm_wrt_q    <= tm_wrt_d;
            tm_wen_q    <= tm_wen_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_err   = rsp_err_q;
    assign tm_adr    = tm_adr_q;
    assign tm_wrt    = tm_wrt_q;
    assign tm_wen    = tm_wen_q;

endmodule

// File: tb/tb_fpga_robots_game_cell_access.sv
// Bench for fpga_robots_game_cell_access: tile map memory model plus a byte-array reference
// of the play area; directed cases followed by randomized commands.
module tb_fpga_robots_game_cell_access;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [1:0]  cmd_val;
    logic        rsp_valid;
    logic [1:0]  rsp_val;
    logic        rsp_err;
    logic [12:0] tm_adr;
    logic [7:0]  tm_red;
    logic [7:0]  tm_wrt;
    logic        tm_wen;

    fpga_robots_game_cell_access dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_val   (cmd_val),
        .rsp_valid (rsp_valid),
        .rsp_val   (rsp_val),
        .rsp_err   (rsp_err),
        .tm_adr    (tm_adr),
        .tm_red    (tm_red),
        .tm_wrt    (tm_wrt),
        .tm_wen    (tm_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tile map: 1-cycle read latency, read returns the pre-write contents
    logic [7:0]  mem [0:8191];
    logic [7:0]  ref_mem [0:8191];
    logic        pre_en, pre_fill;
    logic [12:0] pre_adr;
    logic [7:0]  pre_dat;

    always @(posedge clk) begin
        tm_red <= mem[tm_adr];
        if (pre_fill) begin
            for (int i = 0; i < 8192; i++) mem[i] <= pre_dat;
        end else if (pre_en) begin
            mem[pre_adr] <= pre_dat;
        end else if (tm_wen) begin
            mem[tm_adr] <= tm_wrt;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_adr = a; pre_dat = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic fill(input logic [7:0] d);
        @(negedge clk);
        pre_fill = 1'b1; pre_dat = d;
        @(negedge clk);
        pre_fill = 1'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = d;
    endtask

    // Issues one command, follows it to its response and checks it against the reference
    task automatic run_cmd(input logic [1:0] op, input int x, input int y, input logic [1:0] v);
        bit   oor, do_wr;
        int   adr, sh, old, exp_lat, exp_val, new_b;
        int   k, wen_cnt, wen_k, wrt_first, clr_bad, rdy_bad, diffs;
        logic [12:0] adr_before;

        oor   = (op != 2'd2) && (x >= 120 || y >= 96);
        adr   = ((y / 2) << 7) + x;
        sh    = (y % 2) * 2;
        old   = (int'(ref_mem[adr & 8191]) >> sh) & 3;
        do_wr = !oor && (op == 2'd1 || (op == 2'd3 && old == 0));
        new_b = (int'(ref_mem[adr & 8191]) & ~(3 << sh)) | (int'(v) << sh);
        if (op == 2'd2)  begin exp_lat = 5760; exp_val = 0; end
        else if (oor)    begin exp_lat = 1;    exp_val = 0; end
        else if (do_wr)  begin exp_lat = 3;    exp_val = old; end
        else             begin exp_lat = 2;    exp_val = old; end

        @(negedge clk);
        adr_before = tm_adr;
        expect_eq("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = 7'(x); cmd_y = 7'(y); cmd_val = v;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x = 7'($urandom); cmd_y = 7'($urandom); cmd_val = 2'($urandom);

        k = 0; wen_cnt = 0; wen_k = -1; wrt_first = -1; clr_bad = 0; rdy_bad = 0;
        if (!oor && op != 2'd2) expect_eq("tm_adr_at_E0", tm_adr, adr);
        forever begin
            if (tm_wen) begin
                wen_cnt++;
                if (wen_k < 0) begin wen_k = k; wrt_first = tm_wrt; end
                if (op == 2'd2 && (tm_wrt != 8'h00 || int'(tm_adr) != (((k / 120) << 7) + (k % 120))))
                    clr_bad++;
            end
            if (rsp_valid) break;
            if (cmd_ready) rdy_bad++;
            if (k > 6000) begin
                expect_eq("rsp_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
            k++;
        end

        expect_eq("rsp_latency", k, exp_lat);
        expect_eq("rsp_val", rsp_val, exp_val);
        expect_eq("rsp_err", rsp_err, oor);
        expect_eq("ready_in_rsp", cmd_ready, 1);
        expect_eq("ready_low_while_busy", rdy_bad, 0);
        expect_eq("wen_cycles", wen_cnt, (op == 2'd2) ? 5760 : (do_wr ? 1 : 0));
        if (do_wr) begin
            expect_eq("wen_edge", wen_k, 2);
            expect_eq("tm_wrt", wrt_first, new_b);
        end
        if (oor) expect_eq("adr_unchanged", tm_adr, adr_before);

        if (do_wr) ref_mem[adr] = 8'(new_b);
        if (op == 2'd2) begin
            expect_eq("clr_addr_data", clr_bad, 0);
            for (int r = 0; r < 48; r++)
                for (int c = 0; c < 120; c++) ref_mem[(r << 7) + c] = 8'h00;
            diffs = 0;
            for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) diffs++;
            expect_eq("clr_mem_diffs", diffs, 0);
        end else if (!oor) begin
            expect_eq("mem_byte", mem[adr], ref_mem[adr]);
        end
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_val = '0;
        pre_en = 1'b0; pre_fill = 1'b0; pre_adr = '0; pre_dat = '0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        fill(8'h00);
        #1;
        expect_eq("rst_cmd_ready", cmd_ready, 1);
        expect_eq("rst_rsp_valid", rsp_valid, 0);
        expect_eq("rst_rsp_val", rsp_val, 0);
        expect_eq("rst_rsp_err", rsp_err, 0);
        expect_eq("rst_tm_adr", tm_adr, 0);
        expect_eq("rst_tm_wrt", tm_wrt, 0);
        expect_eq("rst_tm_wen", tm_wen, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted while the write is set up must abort it
        poke(13'h085, 8'hA5);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 7'd5; cmd_y = 7'd3; cmd_val = 2'd2;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("midwr_wen", tm_wen, 1);
        expect_eq("midwr_wrt", tm_wrt, 8'hA9);
        #2 rst = 1'b0;
        #1;
        expect_eq("async_rst_wen", tm_wen, 0);
        expect_eq("async_rst_adr", tm_adr, 0);
        expect_eq("async_rst_ready", cmd_ready, 1);
        expect_eq("async_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("no_write_after_rst", mem[13'h085], 8'hA5);
        expect_eq("ready_after_rst", cmd_ready, 1);

        // Directed cases
        run_cmd(2'd1, 5, 3, 2'd2);
        poke(13'h17F7, 8'h0C);
        run_cmd(2'd0, 119, 95, 2'd0);
        run_cmd(2'd0, 120, 0, 2'd0);
        run_cmd(2'd0, 0, 96, 2'd0);
        poke(13'h010, 8'h01);
        run_cmd(2'd3, 16, 0, 2'd3);
        run_cmd(2'd3, 16, 1, 2'd3);
        fill(8'hFF);
        run_cmd(2'd2, 7, 9, 2'd1);
        expect_eq("status_area_kept", mem[13'h078], 8'hFF);

        // Randomized commands around the play-area edges
        for (int xi = 0; xi < 6; xi++)
            for (int yi = 0; yi < 5; yi++)
                poke(13'((((yi < 3) ? yi : 43 + yi) << 7) + ((xi < 5) ? xi : 119)), 8'($urandom));
        for (int n = 0; n < 80; n++) begin
            int r, x, y;
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == 2'd2) op = 2'd0;
            r = $urandom_range(0, 9);
            x = (r < 5) ? r : 114 + r;
            r = $urandom_range(0, 9);
            y = (r < 5) ? r : 88 + r;
            run_cmd(op, x, y, 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
